// File: rtl/aes_pkg.sv
// Shared AES datapath types: word/state byte arrays and the collector FSM encoding.
// No logic; consumed by the demux, collector, addRoundKey and encrypter.
// Backpressure: n/a.
package aes_pkg;

    localparam int N  = 4;
    localparam int NB = 16;

    typedef logic [N-1:0][7:0]  word_t;
    typedef logic [NB-1:0][7:0] state_t;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } collector_state_e;

endpackage

// File: rtl/mod_block_collector_word_counter.sv
// Saturating 0..WPB word counter with synchronous rst/clr and a load-to-one path.
// Latency: count updates one cycle after the request.
// Backpressure: none; the caller qualifies inc/clr/load1 with its handshakes.
module mod_word_counter #(
    parameter int WPB = 4,
    parameter int CW  = $clog2(WPB + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    input  logic          load1,
    output logic [CW-1:0] cnt
);

    // load1 outranks clr: a word arriving as the full block leaves starts the next block
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= CW'(1);
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CW'(WPB))) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mod_block_collector.sv
// Packs WPB consecutive N-byte words into one NB-byte AES state block (MOD_BLOCK_COLLECTOR_WORDSWAP_EN reverses word order).
// Latency: out_valid rises the cycle after the last word of a block is accepted.
// Backpressure: while a block is held, in_ready follows out_ready so a word only enters as the block leaves.
module mod_block_collector
    import aes_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N-1:0][7:0]             in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NB-1:0][7:0]            out_data,
    output logic [$clog2(NB/N+1)-1:0]     word_cnt
);

    localparam int WPB = NB / N;
    localparam int CW  = $clog2(WPB + 1);
    localparam int IW  = (WPB > 1) ? $clog2(WPB) : 1;

    collector_state_e state, state_nxt;

    logic          cnt_clr;
    logic          cnt_inc;
    logic          cnt_load1;
    logic          wr_en;
    logic [IW-1:0] wr_slot;
    logic [IW-1:0] wr_idx;
    logic [CW-1:0] cnt;

    mod_word_counter #(
        .WPB (WPB),
        .CW  (CW)
    ) u_word_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .load1 (cnt_load1),
        .cnt   (cnt)
    );

    assign word_cnt = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b1;
        out_valid = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        cnt_load1 = 1'b0;
        wr_en     = 1'b0;
        wr_slot   = '0;
        case (state)
            COLLECT: begin
                // clr wins over a concurrent word: the word is dropped
                if (clr) begin
                    cnt_clr = 1'b1;
                end else if (in_valid) begin
                    wr_en   = 1'b1;
                    cnt_inc = 1'b1;
                    wr_slot = cnt[IW-1:0];
                    if (cnt == CW'(WPB - 1)) begin
                        state_nxt = FULL;
                    end
                end
            end
            FULL: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = COLLECT;
                    if (in_valid) begin
                        cnt_load1 = 1'b1;
                        wr_en     = 1'b1;
                    end else begin
                        cnt_clr = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = COLLECT;
            end
        endcase
    end

`ifdef MOD_BLOCK_COLLECTOR_WORDSWAP_EN
    assign wr_idx = IW'(WPB - 1) - wr_slot;
`else
    assign wr_idx = wr_slot;
`endif

    // in_data is only captured under wr_en, so X on an idle bus never reaches out_data
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
        end else if (wr_en) begin
            out_data[N * int'(wr_idx) +: N] <= in_data;
        end
    end

endmodule

// File: tb/tb_mod_block_collector.sv
// Directed + randomized bench for mod_block_collector against a queue-based block model.
module tb_mod_block_collector;

    localparam int WPB = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [3:0][7:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [15:0][7:0] out_data;
    logic [2:0]       word_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    logic          m_full = 1'b0;
    logic [31:0]   m_q[$];
    logic [127:0]  m_blk = '0;

    mod_block_collector dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Block as the host would describe it: word k lands in slot k (or WPB-1-k when swapped)
    function automatic logic [127:0] assemble(input logic [31:0] w0, input logic [31:0] w1,
                                              input logic [31:0] w2, input logic [31:0] w3);
`ifdef MOD_BLOCK_COLLECTOR_WORDSWAP_EN
        return {w0, w1, w2, w3};
`else
        return {w3, w2, w1, w0};
`endif
    endfunction

    // Drive one cycle at the negedge, check outputs mid-phase, advance the model at the posedge
    task automatic step(input logic r, input logic c, input logic v,
                        input logic [31:0] d, input logic ordy);
        logic exp_rdy;
        rst = r; clr = c; in_valid = v; in_data = d; out_ready = ordy;
        #1;
        exp_rdy = !m_full || ordy;
        chk("in_ready", 128'(in_ready), 128'(exp_rdy));
        chk("out_valid", 128'(out_valid), 128'(m_full));
        chk("word_cnt", 128'(word_cnt), m_full ? 128'(WPB) : 128'(m_q.size()));
        if (m_full) chk("out_data", out_data, m_blk);
        @(posedge clk);
        if (r) begin
            m_full = 1'b0;
            m_q.delete();
        end else if (m_full) begin
            if (ordy) begin
                m_full = 1'b0;
                m_q.delete();
                if (v) m_q.push_back(d);
            end
        end else if (c) begin
            m_q.delete();
        end else if (v) begin
            m_q.push_back(d);
            if (m_q.size() == WPB) begin
                m_blk  = assemble(m_q[0], m_q[1], m_q[2], m_q[3]);
                m_full = 1'b1;
                m_q.delete();
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [127:0] exp_seq;
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_out_data", out_data, 128'h0);
        chk("reset_word_cnt", 128'(word_cnt), 128'h0);

        // Reset mid-fill, then a sequential block
        step(0, 0, 1, $urandom, 0);
        step(0, 0, 1, $urandom, 0);
        step(1, 0, 1, $urandom, 0);
        step(0, 0, 1, 32'h03020100, 0);
        step(0, 0, 1, 32'h07060504, 0);
        step(0, 0, 1, 32'h0B0A0908, 0);
        step(0, 0, 1, 32'h0F0E0D0C, 0);
`ifdef MOD_BLOCK_COLLECTOR_WORDSWAP_EN
        exp_seq = 128'h03020100_07060504_0B0A0908_0F0E0D0C;
`else
        exp_seq = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
`endif
        chk("seq_block", out_data, exp_seq);
        step(0, 0, 0, 32'hx, 1);

        // Back-to-back: eight words, sink always ready
        for (int i = 0; i < 8; i++) step(0, 0, 1, $urandom, 1);
        step(0, 0, 0, 32'hx, 1);

        // Backpressure: held block, pending word, then release
        for (int i = 0; i < 4; i++) step(0, 0, 1, $urandom, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 32'hDEADBEEF, 0);
        step(0, 0, 1, 32'hCAFEF00D, 1);
        chk("pending_word_cnt", 128'(word_cnt), 128'h1);
        step(0, 0, 0, 32'hx, 0);

        // clr after partial fill, then a clean block
        step(0, 1, 0, 32'hx, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, $urandom, 0);
        step(0, 1, 0, 32'hx, 0);
        chk("clr_word_cnt", 128'(word_cnt), 128'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, $urandom, 0);

        // clr while FULL is ignored
        step(0, 1, 0, 32'hx, 0);
        step(0, 1, 1, $urandom, 0);
        chk("clr_full_valid", 128'(out_valid), 128'h1);
        step(0, 0, 0, 32'hx, 1);

        // clr together with a word in COLLECT drops the word
        step(0, 0, 1, $urandom, 0);
        step(0, 1, 1, $urandom, 0);
        chk("clr_drop_cnt", 128'(word_cnt), 128'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
                 1'($urandom), $urandom, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
